// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM state
// encodings and the requester-ID width helper.
package mult_share_pkg;

   // FSM state encoding; the unused code 2'b11 recovers to ST_IDLE.
   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'b00;
   localparam state_t ST_MUL  = 2'b01;
   localparam state_t ST_HOLD = 2'b10;

   // Width of a requester index for n requesters (at least 1 bit).
   function automatic int idw_of(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker. Searches the request vector starting one
// position above 'last' and wrapping, returning the first set index.
// 'last' itself has the lowest priority.
module rr_pick #(
   parameter int NREQ = 4,
   localparam int IDW = mult_share_pkg::idw_of(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last,
   output logic [IDW-1:0]  grant,
   output logic            any
);

   // Index 'off' positions above 'base', wrapped into 0..NREQ-1.
   function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                               input int off);
      int s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return s[IDW-1:0];
   endfunction

   // Walk from the lowest priority slot to the highest; the last hit wins,
   // which is the candidate nearest to last+1.
   always_comb begin
      grant = '0;
      any   = |req;
      for (int i = NREQ; i >= 1; i--) begin
         if (req[wrap_add(last, i)]) grant = wrap_add(last, i);
      end
   end

endmodule

// File: rtl/unsigned_multiplier_gen.sv
// Combinational N x N unsigned array multiplier with a full 2N-bit product.
module unsigned_multiplier_gen #(
   parameter int N = 4
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);

   logic [2*N-1:0] pp [N];

   // One shifted partial product per multiplier bit.
   for (genvar i = 0; i < N; i++) begin : g_pp
      assign pp[i] = b[i] ? ({{N{1'b0}}, a} << i) : '0;
   end

   // Sum the partial-product rows.
   always_comb begin
      p = '0;
      for (int i = 0; i < N; i++) begin
         p = p + pp[i];
      end
   end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one combinational multiplier among NREQ requesters. A round-robin
// pick selects one requester in IDLE; its operands are latched, multiplied
// in MUL, and the registered product is held in HOLD until consumed.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer holds valid and its
// payload stable until that transfer. req_ready is one-hot and never depends
// on anything but state, reset and the request vector; rsp_valid/rsp_id/
// rsp_prod are registers and stay stable until rsp_valid & rsp_ready.
module mult_share_arbiter
   import mult_share_pkg::*;
#(
   parameter int N    = 4,
   parameter int NREQ = 4,
   localparam int IDW = mult_share_pkg::idw_of(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_x,
   input  logic [NREQ*N-1:0] req_y,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [2*N-1:0]    rsp_prod,
   output logic              busy
);

   state_t         state;
   state_t         state_nxt;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] grant;
   logic           any;
   logic           accept;
   logic [N-1:0]   x_sel;
   logic [N-1:0]   y_sel;
   logic [N-1:0]   x_q;
   logic [N-1:0]   y_q;
   logic [IDW-1:0] id_q;
   logic [2*N-1:0] prod;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req_valid),
      .last  (last_grant),
      .grant (grant),
      .any   (any)
   );

   unsigned_multiplier_gen #(.N(N)) u_mul (
      .a (x_q),
      .b (y_q),
      .p (prod)
   );

   // An accept happens whenever IDLE sees any request; the picker guarantees
   // the granted requester is valid. Gating with rst_n keeps req_ready low
   // for the whole reset, not just after the first edge.
   assign accept = rst_n && (state == ST_IDLE) && any;
   assign busy   = (state != ST_IDLE);

   // One-hot ready for the granted requester.
   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
   end

   // Select the granted requester's operand pair.
   always_comb begin
      x_sel = '0;
      y_sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant == IDW'(k)) begin
            x_sel = req_x[k*N +: N];
            y_sel = req_y[k*N +: N];
         end
      end
   end

   // Next-state: IDLE -> MUL on accept, MUL -> HOLD always, HOLD -> IDLE
   // once the response is taken. The spare encoding returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_MUL;
         ST_MUL:  state_nxt = ST_HOLD;
         ST_HOLD: if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, round-robin pointer and latched operands. last_grant resets to
   // the top index so requester 0 is searched first after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         last_grant <= IDW'(NREQ - 1);
         x_q        <= '0;
         y_q        <= '0;
         id_q       <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            last_grant <= grant;
            x_q        <= x_sel;
            y_q        <= y_sel;
            id_q       <= grant;
         end
      end
   end

   // Response register: loaded at the end of MUL, cleared when consumed.
   // rsp_ready outside HOLD has no effect because rsp_valid is low there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_prod  <= '0;
      end else begin
         if (state == ST_MUL) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_prod  <= prod;
         end else if (state == ST_HOLD && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios plus a long random run,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mult_share_arbiter;

   localparam int N    = 4;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int PW   = 2 * N;
   localparam int W    = IDW + PW;

   logic              clk;
   logic              rst_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_x;
   logic [NREQ*N-1:0] req_y;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [PW-1:0]     rsp_prod;
   logic              busy;

   mult_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_prod  (rsp_prod),
      .busy      (busy)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   logic [N-1:0]   op_x [NREQ];
   logic [N-1:0]   op_y [NREQ];
   logic [W-1:0]   exp_q [$];
   int             cyc;
   int             last;
   bit             op_active;
   int             acc_cyc;
   int             acc_k;
   bit             rsp_seen;
   int             n_acc;
   int             n_rsp;
   int             wait_cnt [NREQ];

   // observations of the DUT in the last evaluated cycle
   logic [NREQ-1:0] obs_ready;
   logic            obs_rv;
   logic            obs_busy;
   logic [PW-1:0]   obs_prod;
   logic [IDW-1:0]  obs_id;
   logic [PW-1:0]   got_prod;
   int              obs_acc_id [$];
   int              obs_acc_cyc [$];
   int              obs_rsp_prod [$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic pack_ops();
      for (int k = 0; k < NREQ; k++) begin
         req_x[k*N +: N] = op_x[k];
         req_y[k*N +: N] = op_y[k];
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      op_active = 1'b0;
      last      = NREQ - 1;
      for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
   endtask

   // Called at posedge+1 with inputs set; checks this cycle, advances the
   // model across the next rising edge, returns at the following posedge+1.
   task automatic eval_cycle();
      int              win;
      logic [NREQ-1:0] exp_ready;
      logic            exp_rv;
      logic            exp_busy;
      logic [W-1:0]    head;
      pack_ops();
      #1;
      obs_ready = req_ready;
      obs_rv    = rsp_valid;
      obs_busy  = busy;
      obs_prod  = rsp_prod;
      obs_id    = rsp_id;
      for (int k = 0; k < NREQ; k++) if (!req_valid[k]) wait_cnt[k] = 0;
      // round-robin rule: first valid index starting just above the last winner
      win = -1;
      for (int i = 1; i <= NREQ; i++) begin
         if (win < 0 && req_valid[(last + i) % NREQ]) win = (last + i) % NREQ;
      end
      exp_ready = '0;
      if (!op_active && win >= 0) exp_ready[win] = 1'b1;
      exp_rv   = op_active && (cyc >= acc_cyc + 2);
      exp_busy = op_active && (cyc > acc_cyc);
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check_eq("busy", 32'(busy), 32'(exp_busy));
      acc_k    = -1;
      rsp_seen = 1'b0;
      if ((req_ready & req_valid) != '0) begin
         for (int k = 0; k < NREQ; k++) if (req_ready[k]) obs_acc_id.push_back(k);
         obs_acc_cyc.push_back(cyc);
      end
      if (exp_rv) begin
         head = exp_q[0];
         check_eq("rsp_id", 32'(rsp_id), 32'(head[W-1:PW]));
         check_eq("rsp_prod", 32'(rsp_prod), 32'(head[PW-1:0]));
         if (rsp_ready) begin
            got_prod = rsp_prod;
            rsp_seen = 1'b1;
            obs_rsp_prod.push_back(int'(rsp_prod));
            void'(exp_q.pop_front());
            op_active = 1'b0;
            n_rsp++;
         end
      end
      if (exp_ready != '0) begin
         acc_k = win;
         check_eq("starve", 32'(wait_cnt[win] <= NREQ - 1), 32'd1);
         for (int k = 0; k < NREQ; k++) if (k != win && req_valid[k]) wait_cnt[k]++;
         wait_cnt[win] = 0;
         exp_q.push_back({IDW'(win), PW'(int'(op_x[win]) * int'(op_y[win]))});
         op_active = 1'b1;
         acc_cyc   = cyc;
         last      = win;
         n_acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Asynchronous reset asserted away from the clock edge; rsp_valid must
   // drop at once. Returns at posedge+1 with reset released.
   task automatic reset_now(input int hold_cycles);
      rst_n = 1'b0;
      #1;
      check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rst_rsp_prod", 32'(rsp_prod), 32'd0);
      check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_req_ready", 32'(req_ready), 32'd0);
      for (int i = 0; i < hold_cycles; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         check_eq("rst_hold_ready", 32'(req_ready), 32'd0);
         check_eq("rst_hold_valid", 32'(rsp_valid), 32'd0);
      end
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic run_until_acc();
      for (int i = 0; i < 20; i++) begin
         eval_cycle();
         if (acc_k >= 0) return;
      end
      check_eq("acc_timeout", 32'd0, 32'd1);
   endtask

   task automatic run_until_rsp();
      for (int i = 0; i < 40; i++) begin
         eval_cycle();
         if (rsp_seen) return;
      end
      check_eq("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic single_op(input int k, input logic [N-1:0] x, input logic [N-1:0] y,
                            output logic [PW-1:0] p);
      op_x[k]   = x;
      op_y[k]   = y;
      req_valid = NREQ'(1) << k;
      run_until_acc();
      req_valid = '0;
      run_until_rsp();
      p = got_prod;
   endtask

   logic [PW-1:0] p;
   logic [N-1:0]  bx [4];
   logic [N-1:0]  by [4];
   logic [PW-1:0] bp [4];
   int            exp_ids [5];
   int            rand_ops;

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      cyc       = 0;
      acc_cyc   = 0;
      n_acc     = 0;
      n_rsp     = 0;
      for (int k = 0; k < NREQ; k++) begin
         op_x[k] = '0;
         op_y[k] = '0;
      end
      pack_ops();
      model_reset();
      @(posedge clk);
      #1;
      reset_now(2);

      // single request, 15 x 15 from requester 2
      op_x[2]   = 4'hF;
      op_y[2]   = 4'hF;
      req_valid = 4'b0100;
      eval_cycle();
      check_eq("t1_ready", 32'(obs_ready), 32'h4);
      req_valid = '0;
      eval_cycle();
      check_eq("t1_mul_rv", 32'(obs_rv), 32'd0);
      eval_cycle();
      check_eq("t1_rv", 32'(obs_rv), 32'd1);
      check_eq("t1_prod", 32'(obs_prod), 32'hE1);
      check_eq("t1_id", 32'(obs_id), 32'd2);

      // all requesters continuously valid: order 0,1,2,3,0 every 3 cycles
      reset_now(1);
      for (int k = 0; k < NREQ; k++) begin
         op_x[k] = N'(k + 1);
         op_y[k] = 4'd3;
      end
      obs_acc_id.delete();
      obs_acc_cyc.delete();
      obs_rsp_prod.delete();
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 14; i++) eval_cycle();
      req_valid = '0;
      for (int i = 0; i < 3; i++) eval_cycle();
      exp_ids = '{0, 1, 2, 3, 0};
      check_eq("t2_n_acc", 32'(obs_acc_id.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < obs_acc_id.size()) check_eq("t2_order", 32'(obs_acc_id[i]), 32'(exp_ids[i]));
         if (i > 0 && i < obs_acc_cyc.size())
            check_eq("t2_spacing", 32'(obs_acc_cyc[i] - obs_acc_cyc[i-1]), 32'd3);
      end
      for (int i = 0; i < 4; i++) begin
         if (i < obs_rsp_prod.size()) check_eq("t2_prod", 32'(obs_rsp_prod[i]), 32'(3 * (i + 1)));
      end

      // backpressure: 7 x 9 held for five cycles, other requester waits
      op_x[0]   = 4'h7;
      op_y[0]   = 4'h9;
      op_x[1]   = 4'h2;
      op_y[1]   = 4'h2;
      rsp_ready = 1'b0;
      req_valid = 4'b0001;
      run_until_acc();
      req_valid = 4'b0010;
      eval_cycle();
      for (int i = 0; i < 5; i++) begin
         eval_cycle();
         check_eq("t3_hold_rv", 32'(obs_rv), 32'd1);
         check_eq("t3_hold_prod", 32'(obs_prod), 32'h3F);
         check_eq("t3_hold_ready", 32'(obs_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      eval_cycle();
      eval_cycle();
      check_eq("t3_idle_busy", 32'(obs_busy), 32'd0);
      check_eq("t3_next_ready", 32'(obs_ready), 32'h2);
      req_valid = '0;
      run_until_rsp();

      // reset during MUL, then during HOLD
      op_x[0]   = 4'h5;
      op_y[0]   = 4'h5;
      req_valid = 4'b0001;
      run_until_acc();
      reset_now(2);
      op_x[1]   = 4'h3;
      op_y[1]   = 4'h4;
      op_x[3]   = 4'h6;
      op_y[3]   = 4'h6;
      req_valid = 4'b1010;
      eval_cycle();
      check_eq("t4_first_after_rst", 32'(obs_ready), 32'h2);
      req_valid = '0;
      rsp_ready = 1'b0;
      eval_cycle();
      eval_cycle();
      check_eq("t4_hold_rv", 32'(obs_rv), 32'd1);
      reset_now(1);
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         eval_cycle();
         check_eq("t4_no_ghost", 32'(obs_rv), 32'd0);
      end
      op_x[2]   = 4'h1;
      op_y[2]   = 4'h1;
      req_valid = 4'b1100;
      eval_cycle();
      check_eq("t4_lowest", 32'(obs_ready), 32'h4);
      req_valid = 4'b1000;
      run_until_acc();
      req_valid = '0;
      run_until_rsp();

      // boundary operands through requester 3
      bx = '{4'h0, 4'h0, 4'h1, 4'hF};
      by = '{4'h0, 4'hF, 4'hF, 4'h1};
      bp = '{8'h00, 8'h00, 8'h0F, 8'h0F};
      for (int i = 0; i < 4; i++) begin
         single_op(3, bx[i], by[i], p);
         check_eq("t5_boundary", 32'(p), 32'(bp[i]));
      end

      // random traffic against the model
      reset_now(1);
      n_acc    = 0;
      n_rsp    = 0;
      rand_ops = 0;
      for (int c = 0; c < 60000 && n_rsp < 10000; c++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (!req_valid[k] && $urandom_range(0, 3) != 0) begin
               req_valid[k] = 1'b1;
               op_x[k]      = N'($urandom_range(0, 15));
               op_y[k]      = N'($urandom_range(0, 15));
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         eval_cycle();
         if (acc_k >= 0) req_valid[acc_k] = 1'b0;
      end
      check_eq("rand_budget", 32'(n_rsp >= 10000), 32'd1);
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) eval_cycle();
      check_eq("rand_queue_empty", 32'(exp_q.size()), 32'd0);
      check_eq("rand_acc_eq_rsp", 32'(n_rsp), 32'(n_acc));
      check_eq("rand_final_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one combinational N×N unsigned array multiplier among NREQ requesters. It accepts one operand pair at a time through a valid/ready handshake and latches the operands. It then registers the product and presents it with the winner's ID on a single response channel until that response is consumed. It sits between the requesting datapath blocks and the multiplier instance.

## Interface
- N, default 4: operand width; product is 2N bits.
- NREQ, default 4: number of requesters, 2..8; IDW = clog2(NREQ).
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request.
- req_ready  out  NREQ  one-hot accept; combinational from state and grant.
- req_x  in  NREQ*N  operand x, requester k at bits [k*N +: N].
- req_y  in  NREQ*N  operand y, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of requester that owns rsp_prod.
- rsp_prod  out  2N  registered unsigned product x*y.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MUL, HOLD.
- **IDLE**
  - grant = first k with req_valid[k] set, searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[grant] = 1 only if some request is valid; all other bits are 0.
  - On handshake: latch x_q, y_q, id_q, set last_grant = grant, go to MUL.
  - No valid requests: stay in IDLE, req_ready = 0.
- **MUL**
  - The multiplier sees x_q and y_q.
  - At the end of the cycle: rsp_prod <= product, rsp_id <= id_q, rsp_valid <= 1, go to HOLD.
- **HOLD**
  - rsp_valid, rsp_id and rsp_prod stay stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid <= 0, go to IDLE.
  - No requests are accepted in HOLD.
- Arithmetic: full-width unsigned, no truncation. (2^N−1)² fits in 2N bits.
- Requester contract: a requester holds req_valid and its operands until it sees req_ready; the block does not check this. Deasserting req_valid before the grant simply drops that requester from arbitration.

## Timing
- Reset values: state = IDLE, last_grant = NREQ−1 (so requester 0 has first priority), rsp_valid = 0, rsp_id = 0, rsp_prod = 0, busy = 0, x_q = y_q = id_q = 0.
- req_ready = 0 throughout reset.
- Latency: accept in cycle t; rsp_valid is visible in cycle t+2.
- Throughput: one operation every 3 cycles with rsp_ready tied high (IDLE → MUL → HOLD → IDLE).
- Backpressure: each cycle rsp_ready is low adds one HOLD cycle.
- Simultaneous requests: exactly one grant per accept. A requester that stays valid is served within NREQ accepts.
- Wrap-around: after last_grant = NREQ−1, the search starts at 0.
- Reset mid-operation (MUL or HOLD): the pending result is discarded and rsp_valid drops asynchronously. After release, arbitration restarts from requester 0.
- rsp_ready while rsp_valid = 0: ignored.

## Structure
- Shared package mult_share_pkg holds:
  - state typedef with encodings IDLE = 2'b00, MUL = 2'b01, HOLD = 2'b10 (2'b11 recovers to IDLE);
  - the IDW helper function.
- Sub-module: one instance of the team's unsigned_multiplier_gen #(N), driven by x_q and y_q.
- Sub-module: the round-robin priority picker as rr_pick #(NREQ) (inputs req, last; outputs grant, any). It is unit-testable on its own.
- Everything else (FSM, operand registers, response register) lives in the top module.

## Test plan
- Reset, then a single request: req_valid[2] = 1, x = 4'hF, y = 4'hF. Expect req_ready[2] in that cycle, then rsp_valid 2 cycles later with rsp_prod = 8'hE1, rsp_id = 2.
- All four requests valid continuously, operands k+1 × 3, rsp_ready = 1. Expect grant order 0, 1, 2, 3, 0, with one accept every 3 cycles and products 3, 6, 9, 12.
- Backpressure: rsp_ready held 0 for 5 cycles with 4'h7 × 4'h9. Expect rsp_prod = 8'h3F held stable and req_ready = 0 throughout; return to IDLE the cycle after rsp_ready = 1.
- Reset asserted in MUL and again in HOLD. Expect rsp_valid = 0 immediately and no response after release. The next accept goes to the lowest valid index.
- Boundary operands 0×0, 0×F, 1×F, F×1. Expect 0, 0, 8'h0F, 8'h0F.
- Random: 10,000 operations with random valids, operands and rsp_ready, scoreboarded against x*y per ID. Check no starvation (gap ≤ NREQ accepts while valid) and no response is lost or duplicated.
